coord_fetch_seq: RTL and testbench

- Upstream sequencer for the per-channel coordinate ROM (16-bit x/z per channel, 1-cycle registered read).
- On a start pulse, sweeps ROM addresses 0..NUM_CHANNELS-1 and compensates for the ROM read latency.
- Delivers (index, x, z, last) as a valid/ready stream to the downstream delay-calculation stage.
- Absorbs downstream backpressure in a small FIFO, so no coordinate is dropped or duplicated.

---
 rtl/coord_fetch_seq_pkg.sv | 29 ++
 rtl/coord_fifo.sv | 65 ++++++
 rtl/coord_fetch_seq.sv | 134 +++++++++++++
 tb/tb_coord_fetch_seq.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coord_fetch_seq_pkg.sv
// Shared types and constants for the coordinate fetch sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package coord_fetch_seq_pkg;

    // Width of one x or z coordinate word held in the channel ROM.
    localparam int COORD_WIDTH      = 16;
    // The coordinate ROM returns data one cycle after the address is presented.
    localparam int ROM_READ_LATENCY = 1;
    // Widest channel index any build is expected to carry in a coord element.
    localparam int IDX_W_MAX        = 16;

    // One delivered coordinate element.
    typedef struct packed {
        logic [IDX_W_MAX-1:0]   idx;
        logic [COORD_WIDTH-1:0] x;
        logic [COORD_WIDTH-1:0] z;
        logic                   last;
    } coord_elem_t;

    // Sweep controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/coord_fifo.sv
// Generic synchronous FIFO with occupancy count; head is shown combinationally.
// Latency: a pushed word is visible at the head one cycle after the push.
// Backpressure: producer must respect count; push+pop in one cycle are both honoured.
module coord_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    // A pop frees the slot a same-cycle push lands in, so full+pop+push is legal.
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign head_dat = mem[rd_ptr];

    // Storage array; no reset needed since reads are qualified by empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    overflow_chk: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && full && !pop));

endmodule

// File: rtl/coord_fetch_seq.sv
// Sweeps the coordinate ROM on start and streams (idx, x, z, last) downstream.
// Latency: start at T -> first rom_addr at T+1 -> first out_valid at T+3, then 1/cycle.
// Backpressure: ROM reads are credit-limited by FIFO occupancy plus the in-flight read.
module coord_fetch_seq #(
    parameter int NUM_CHANNELS = 16,
    parameter int ADDR_WIDTH   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
    parameter int COORD_WIDTH  = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic [ADDR_WIDTH-1:0]  rom_addr,
    input  logic [COORD_WIDTH-1:0] rom_x,
    input  logic [COORD_WIDTH-1:0] rom_z,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ADDR_WIDTH-1:0]  out_idx,
    output logic [COORD_WIDTH-1:0] out_x,
    output logic [COORD_WIDTH-1:0] out_z,
    output logic                   out_last
);
    import coord_fetch_seq_pkg::*;

    localparam int CNT_W  = $clog2(NUM_CHANNELS + 1);
    localparam int FCNT_W = ((FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1) + 1;
    localparam int ELEM_W = ADDR_WIDTH + 2 * COORD_WIDTH + 1;
    localparam logic [CNT_W-1:0]      N_CNT    = CNT_W'(NUM_CHANNELS);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_CHANNELS - 1);

    fetch_state_t            state_q;
    fetch_state_t            state_d;
    logic [CNT_W-1:0]        issue_cnt_q;
    logic [CNT_W-1:0]        out_cnt_q;
    logic                    inflight_q;
    logic [ADDR_WIDTH-1:0]   rom_addr_q;
    logic [ADDR_WIDTH-1:0]   cap_idx_q;
    logic [ADDR_WIDTH-1:0]   issue_addr;
    logic                    credit_ok;
    logic                    issue;
    logic                    last_issue;
    logic                    pop;
    logic                    fifo_empty;
    logic [FCNT_W-1:0]       fifo_count;
    logic [ELEM_W-1:0]       push_dat;
    logic [ELEM_W-1:0]       head_dat;

    // The in-flight read already owns a FIFO slot, so it is counted as a credit.
    assign credit_ok  = (int'(fifo_count) + int'(inflight_q)) < FIFO_DEPTH;
    assign issue      = (state_q == ST_FETCH) && (issue_cnt_q < N_CNT) && credit_ok;
    assign issue_addr = ADDR_WIDTH'(issue_cnt_q);
    assign last_issue = issue && (issue_cnt_q == N_CNT - CNT_W'(1));
    // The address goes out in the issue cycle so data returns the next cycle.
    assign rom_addr   = issue ? issue_addr : rom_addr_q;

    assign pop        = out_valid && out_ready;
    assign busy       = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
    assign done       = (state_q == ST_DONE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; DRAIN exits in the same cycle as the final handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_FETCH;
            ST_FETCH: if (last_issue) state_d = ST_DRAIN;
            ST_DRAIN: if ((out_cnt_q + CNT_W'(pop)) == N_CNT) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Sweep counters, read-in-flight flag and the index pipeline that tracks the ROM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt_q <= '0;
            out_cnt_q   <= '0;
            inflight_q  <= 1'b0;
            rom_addr_q  <= '0;
            cap_idx_q   <= '0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                rom_addr_q <= issue_addr;
                cap_idx_q  <= issue_addr;
            end
            if ((state_q == ST_IDLE) && start) begin
                issue_cnt_q <= '0;
                out_cnt_q   <= '0;
            end else begin
                if (issue) begin
                    issue_cnt_q <= issue_cnt_q + CNT_W'(1);
                end
                if (pop) begin
                    out_cnt_q <= out_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign push_dat = {cap_idx_q, rom_x, rom_z, (cap_idx_q == LAST_IDX)};

    coord_fifo #(
        .WIDTH (ELEM_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (inflight_q),
        .push_dat (push_dat),
        .pop      (pop),
        .head_dat (head_dat),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // Outputs read as zero whenever nothing is buffered, including after reset.
    assign out_valid = !fifo_empty;
    assign out_idx   = out_valid ? head_dat[ELEM_W-1 -: ADDR_WIDTH] : '0;
    assign out_x     = out_valid ? head_dat[2*COORD_WIDTH -: COORD_WIDTH] : '0;
    assign out_z     = out_valid ? head_dat[COORD_WIDTH -: COORD_WIDTH] : '0;
    assign out_last  = out_valid && head_dat[0];

endmodule

// File: tb/tb_coord_fetch_seq.sv
// Bench for coord_fetch_seq: 16-channel build plus a 1-channel build.
// Latency: n/a.
// Backpressure: out_ready patterns driven from directed vectors.
module tb_coord_fetch_seq;
    import coord_fetch_seq_pkg::*;

    localparam int N  = 16;
    localparam int AW = 4;
    localparam int CW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          rst_n, start, busy, done, out_valid, out_ready, out_last;
    logic [AW-1:0] rom_addr, out_idx;
    logic [CW-1:0] rom_x, rom_z, out_x, out_z;

    logic          start1, busy1, done1, out_valid1, out_ready1, out_last1;
    logic [0:0]    rom_addr1, out_idx1;
    logic [CW-1:0] rom_x1, rom_z1, out_x1, out_z1;

    // Coordinate ROMs: x = 0x1000+i, z = 0x2000+i, one-cycle registered read.
    always @(posedge clk) begin
        rom_x  <= 16'h1000 + 16'(rom_addr);
        rom_z  <= 16'h2000 + 16'(rom_addr);
        rom_x1 <= 16'h1000 + 16'(rom_addr1);
        rom_z1 <= 16'h2000 + 16'(rom_addr1);
    end

    coord_fetch_seq #(.NUM_CHANNELS(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .rom_addr(rom_addr), .rom_x(rom_x), .rom_z(rom_z),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
        .out_x(out_x), .out_z(out_z), .out_last(out_last)
    );

    coord_fetch_seq #(.NUM_CHANNELS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
        .rom_addr(rom_addr1), .rom_x(rom_x1), .rom_z(rom_z1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_idx(out_idx1),
        .out_x(out_x1), .out_z(out_z1), .out_last(out_last1)
    );

    int   n_chk = 0;
    int   n_err = 0;
    int   run_gen = 0;
    int   seen_gen = 0;
    int   fv_gen = 0;
    int   sb_idx = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   first_valid_cyc = 0;
    int   last_hs_cyc = 0;
    int   max_cnt = 0;
    logic done_exp = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Expected element i of a sweep over n channels.
    function automatic coord_elem_t model_elem(input int i, input int n);
        coord_elem_t e;
        e.idx  = IDX_W_MAX'(i);
        e.x    = 16'h1000 + 16'(i);
        e.z    = 16'h2000 + 16'(i);
        e.last = (i == n - 1);
        return e;
    endfunction

    // Scoreboard: in-order stream of channels, done exactly one cycle after the last handshake.
    task automatic monitor();
        coord_elem_t act_e;
        coord_elem_t exp_e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb_idx   = 0;
                done_exp = 1'b0;
            end else begin
                if (seen_gen != run_gen) begin
                    seen_gen = run_gen;
                    sb_idx   = 0;
                end
                chk("done_pulse", 64'(done), 64'(done_exp));
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                done_exp = 1'b0;
                if (int'(dut.u_fifo.count) > max_cnt) max_cnt = int'(dut.u_fifo.count);
                if (out_valid) begin
                    if (fv_gen != run_gen) begin
                        fv_gen          = run_gen;
                        first_valid_cyc = cyc;
                    end
                    act_e.idx  = IDX_W_MAX'(out_idx);
                    act_e.x    = out_x;
                    act_e.z    = out_z;
                    act_e.last = out_last;
                    exp_e      = model_elem(sb_idx, N);
                    chk("stream_elem", {15'd0, act_e}, {15'd0, exp_e});
                    if (out_ready) begin
                        if (sb_idx == N - 1) begin
                            last_hs_cyc = cyc;
                            done_exp    = 1'b1;
                        end
                        sb_idx++;
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input bit new_run, output int t);
        if (new_run) run_gen++;
        start = 1'b1;
        t     = cyc;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string nm);
        bit seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            #1;
            if (done === 1'b1) seen = 1'b1;
        end
        chk(nm, 64'(seen), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int  t0;
        int  dc0;
        bit  seen;
        logic [3:0] patv;
        patv = 4'b1001;
        rst_n = 1'b0; start = 1'b0; out_ready = 1'b1; start1 = 1'b0; out_ready1 = 1'b1;
        fork
            monitor();
        join_none

        // Reset state.
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_done",      64'(done),      64'd0);
        chk("rst_rom_addr",  64'(rom_addr),  64'd0);
        chk("rst_out_data",  {out_idx, out_x, out_z, out_last}, 64'd0);
        chk("rst_valid_n1",  64'(out_valid1), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(); step();

        // Full sweep with out_ready held high.
        pulse_start(1'b1, t0);
        chk("busy_after_start", 64'(busy), 64'd1);
        wait_done(100, "t1_done_seen");
        chk("t1_first_valid_lat", 64'(first_valid_cyc - t0), 64'd3);
        chk("t1_last_hs_lat",     64'(last_hs_cyc - t0),     64'd18);
        chk("t1_done_lat",        64'(done_cyc - t0),        64'd19);
        chk("t1_count",           64'(sb_idx),               64'd16);
        step();
        chk("t1_busy_after", 64'(busy), 64'd0);
        chk("t1_done_after", 64'(done), 64'd0);

        // out_ready pattern 1,0,0,1.
        max_cnt = 0;
        pulse_start(1'b1, t0);
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            out_ready = patv[k % 4];
            @(negedge clk);
            #1;
            if (done === 1'b1) seen = 1'b1;
            step();
        end
        chk("t2_done_seen", 64'(seen), 64'd1);
        chk("t2_count",     64'(sb_idx), 64'd16);
        chk("t2_fifo_peak_le4", 64'(max_cnt <= 4), 64'd1);
        out_ready = 1'b1;
        step();

        // Long stall: exactly four elements buffered, fetch stops at address 3.
        out_ready = 1'b0;
        pulse_start(1'b1, t0);
        repeat (19) step();
        @(negedge clk);
        #1;
        chk("t3_valid",      64'(out_valid), 64'd1);
        chk("t3_head_idx",   64'(out_idx),   64'd0);
        chk("t3_head_x",     64'(out_x),     64'h1000);
        chk("t3_rom_addr",   64'(rom_addr),  64'd3);
        chk("t3_fifo_count", 64'(dut.u_fifo.count), 64'd4);
        chk("t3_busy",       64'(busy),      64'd1);
        step();
        out_ready = 1'b1;
        wait_done(100, "t3_done_seen");
        chk("t3_count", 64'(sb_idx), 64'd16);
        step(); step();

        // Start re-pulsed mid-sweep and in the DONE cycle: both ignored.
        dc0 = done_cnt;
        pulse_start(1'b1, t0);
        repeat (4) step();
        pulse_start(1'b0, t0);
        repeat (13) step();
        chk("t4_done_cycle", 64'(done), 64'd1);
        pulse_start(1'b0, t0);
        repeat (25) step();
        chk("t4_one_done", 64'(done_cnt - dc0), 64'd1);
        chk("t4_count",    64'(sb_idx),         64'd16);
        chk("t4_idle",     {62'd0, busy, out_valid}, 64'd0);

        // Reset mid-sweep aborts asynchronously, then a clean sweep follows.
        step(); step();
        pulse_start(1'b1, t0);
        repeat (7) step();
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid",    64'(out_valid), 64'd0);
        chk("t5_rst_busy",     64'(busy),      64'd0);
        chk("t5_rst_rom_addr", 64'(rom_addr),  64'd0);
        chk("t5_rst_data",     {out_idx, out_x, out_z, out_last}, 64'd0);
        dc0 = done_cnt;
        repeat (3) step();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) step();
        chk("t5_no_done", 64'(done_cnt - dc0), 64'd0);
        pulse_start(1'b1, t0);
        wait_done(100, "t5_done_seen");
        chk("t5_count",             64'(sb_idx),                64'd16);
        chk("t5_first_valid_lat",   64'(first_valid_cyc - t0),  64'd3);
        step(); step();

        // Single-channel build.
        start1 = 1'b1;
        t0 = cyc;
        step();
        start1 = 1'b0;
        chk("n1_busy", 64'(busy1), 64'd1);
        step();
        @(negedge clk);
        chk("n1_valid_t2", 64'(out_valid1), 64'd0);
        step();
        @(negedge clk);
        chk("n1_elem_t3", {out_valid1, out_idx1, out_last1, out_x1, out_z1},
            {1'b1, 1'b0, 1'b1, 16'h1000, 16'h2000});
        chk("n1_done_t3", 64'(done1), 64'd0);
        step();
        @(negedge clk);
        chk("n1_done_t4",  64'(done1),      64'd1);
        chk("n1_valid_t4", 64'(out_valid1), 64'd0);
        step();
        @(negedge clk);
        chk("n1_idle_t5", {62'd0, done1, busy1}, 64'd0);
        chk("n1_timing_ref", 64'(cyc - t0), 64'd5);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
